// File: rtl/fifo_bank_array.sv
// rtl/fifo_bank_array.sv - array of independent synchronous FIFO banks with masks, flags and flush
// Optional sticky overflow/underflow flags: define FIFO_BANK_ERR_EN.
module fifo_bank_array #(
    parameter int NUM_BANKS     = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH_WIDTH   = 4,
    parameter int AFULL_THRESH  = (1 << DEPTH_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [NUM_BANKS-1:0]   wr_mask_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i [NUM_BANKS],
    input  logic                   rd_en_i,
    input  logic [NUM_BANKS-1:0]   rd_mask_i,
    output logic [DATA_WIDTH-1:0]  rd_data_o [NUM_BANKS],
    output logic [NUM_BANKS-1:0]   rd_valid_o,
    output logic [NUM_BANKS-1:0]   full_o,
    output logic [NUM_BANKS-1:0]   empty_o,
    output logic [NUM_BANKS-1:0]   almost_full_o,
    output logic [NUM_BANKS-1:0]   almost_empty_o,
    output logic [DEPTH_WIDTH:0]   count_o [NUM_BANKS],
    output logic                   any_full_o,
    output logic                   all_empty_o,
    output logic [NUM_BANKS-1:0]   ovf_o,
    output logic [NUM_BANKS-1:0]   udf_o
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] DEPTH_L  = DEPTH[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] AFULL_L  = AFULL_THRESH[DEPTH_WIDTH:0];
    localparam logic [DEPTH_WIDTH:0] AEMPTY_L = AEMPTY_THRESH[DEPTH_WIDTH:0];

    assign any_full_o  = |full_o;
    assign all_empty_o = &empty_o;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
        logic [DEPTH_WIDTH:0]   r_wr_ptr;
        logic [DEPTH_WIDTH:0]   r_rd_ptr;
        logic [DATA_WIDTH-1:0]  r_rd_data;
        logic                   r_rd_valid;
        logic [DEPTH_WIDTH:0]   w_count;
        logic                   w_full;
        logic                   w_empty;
        logic                   w_wr_req;
        logic                   w_rd_req;
        logic                   w_wr_acc;
        logic                   w_rd_acc;

        // Occupancy is the pointer distance; the extra MSB disambiguates full from empty.
        assign w_count  = r_wr_ptr - r_rd_ptr;
        assign w_full   = (w_count == DEPTH_L);
        assign w_empty  = (w_count == '0);
        assign w_wr_req = wr_en_i & wr_mask_i[b];
        assign w_rd_req = rd_en_i & rd_mask_i[b];
        // Flush wins over traffic; a full bank still takes a write when a read frees a slot.
        assign w_rd_acc = w_rd_req & ~w_empty & ~flush_i;
        assign w_wr_acc = w_wr_req & (~w_full | w_rd_acc) & ~flush_i;

        assign full_o[b]         = w_full;
        assign empty_o[b]        = w_empty;
        assign almost_full_o[b]  = (w_count >= AFULL_L);
        assign almost_empty_o[b] = (w_count <= AEMPTY_L);
        assign count_o[b]        = w_count;
        assign rd_data_o[b]      = r_rd_data;
        assign rd_valid_o[b]     = r_rd_valid;

        // Pointer advance on accepted transfers; flush rewinds both to zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end

        // Storage array; contents need no reset since pointers gate visibility.
        always_ff @(posedge clk) begin
            if (w_wr_acc) r_mem[r_wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data_i[b];
        end

        // Registered read port: data holds between reads, valid pulses one cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[DEPTH_WIDTH-1:0]];
            end
        end

`ifdef FIFO_BANK_ERR_EN
        logic r_ovf;
        logic r_udf;

        // Sticky error flags for dropped writes and reads of an empty bank.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else if (flush_i) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_wr_req & ~w_wr_acc) r_ovf <= 1'b1;
                if (w_rd_req & ~w_rd_acc) r_udf <= 1'b1;
            end
        end

        assign ovf_o[b] = r_ovf;
        assign udf_o[b] = r_udf;
`else
        assign ovf_o[b] = 1'b0;
        assign udf_o[b] = 1'b0;
`endif
    end

endmodule
